// File: rtl/regfile_bypass_if.sv
// rtl/regfile_bypass_if.sv - Register file write/read port bundle
interface regfile_bypass_if #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic             RegWrite;
    logic [AW-1:0]    WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic [AW-1:0]    ReadRegister1;
    logic [AW-1:0]    ReadRegister2;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - 32x64 register file, hardwired-zero X31, write-through bypass
module regfile_bypass #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic            clk,
    input  logic            reset,
    regfile_bypass_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic [NREGS-1:0] wr_en;
    logic [WIDTH-1:0] rd_vec [NREGS];
    logic             byp_ok;

    // One-hot write decode; writes to the zero register never enable anything
    always_comb begin
        wr_en = '0;
        if (bus.RegWrite && (bus.WriteRegister != ZERO_IDX)) begin
            wr_en[bus.WriteRegister] = 1'b1;
        end
    end

    // Storage: one enabled register per index, except the zero register which has none
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign rd_vec[i] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] q;

            // Reset clears the entry and wins over a same-cycle write
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else if (wr_en[i]) begin
                    q <= bus.WriteData;
                end
            end

            assign rd_vec[i] = q;
        end
    end

    // Bypass is disabled while reset is asserted so reads show pre-clear contents
    assign byp_ok = bus.RegWrite && !reset;

    // Read port 1: zero register, then bypass, then stored value
    always_comb begin
        if (bus.ReadRegister1 == ZERO_IDX) begin
            bus.ReadData1 = '0;
        end else if (byp_ok && (bus.WriteRegister == bus.ReadRegister1)) begin
            bus.ReadData1 = bus.WriteData;
        end else begin
            bus.ReadData1 = rd_vec[bus.ReadRegister1];
        end
    end

    // Read port 2: same priority as port 1, fully independent
    always_comb begin
        if (bus.ReadRegister2 == ZERO_IDX) begin
            bus.ReadData2 = '0;
        end else if (byp_ok && (bus.WriteRegister == bus.ReadRegister2)) begin
            bus.ReadData2 = bus.WriteData;
        end else begin
            bus.ReadData2 = rd_vec[bus.ReadRegister2];
        end
    end
endmodule

// File: tb/tb_regfile_bypass.sv
// tb/tb_regfile_bypass.sv - Directed self-checking bench for regfile_bypass
module tb_regfile_bypass;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    regfile_bypass_if #(.WIDTH(64), .NREGS(32)) rf_if ();

    regfile_bypass #(.WIDTH(64), .NREGS(32), .ZERO_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance through one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        rf_if.RegWrite      = we;
        rf_if.WriteRegister = wa;
        rf_if.WriteData     = wd;
        rf_if.ReadRegister1 = ra1;
        rf_if.ReadRegister2 = ra2;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd30);
        tick();
        tick();

        // Reset state
        reset = 1'b0;
        drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd30);
        check_val("rst_x0", rf_if.ReadData1, 64'h0);
        check_val("rst_x30", rf_if.ReadData2, 64'h0);

        // Test 1: reset clears a written register
        drive(1'b1, 5'd5, 64'hDEADBEEF, 5'd6, 5'd6);
        tick();
        reset = 1'b1;
        drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd0);
        check_val("t1_in_reset_x5", rf_if.ReadData1, 64'hDEADBEEF);
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd0);
        check_val("t1_x5_cleared", rf_if.ReadData1, 64'h0);
        check_val("t1_x0_cleared", rf_if.ReadData2, 64'h0);

        // Test 2: write and read back every storage register on both ports
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 5'(i), 64'h1111_0000_0000_0000 + 64'(i), 5'd31, 5'd31);
            tick();
        end
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 5'd0, 64'h0, 5'(i), 5'(30 - i));
            check_val($sformatf("t2_rd1_x%0d", i), rf_if.ReadData1, 64'h1111_0000_0000_0000 + 64'(i));
            check_val($sformatf("t2_rd2_x%0d", 30 - i), rf_if.ReadData2, 64'h1111_0000_0000_0000 + 64'(30 - i));
        end

        // Test 3: writes to X31 are discarded and never bypassed
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
        check_val("t3_same_rd1", rf_if.ReadData1, 64'h0);
        check_val("t3_same_rd2", rf_if.ReadData2, 64'h0);
        tick();
        drive(1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
        check_val("t3_next_rd1", rf_if.ReadData1, 64'h0);
        check_val("t3_next_rd2", rf_if.ReadData2, 64'h0);
        drive(1'b0, 5'd0, 64'h0, 5'd30, 5'd0);
        check_val("t3_x30_intact", rf_if.ReadData1, 64'h1111_0000_0000_001E);

        // Test 4: same-cycle bypass on one port, stored value on the other
        drive(1'b1, 5'd7, 64'h5, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 64'hA5A5_A5A5_A5A5_A5A5, 5'd7, 5'd8);
        check_val("t4_bypass_rd1", rf_if.ReadData1, 64'hA5A5_A5A5_A5A5_A5A5);
        check_val("t4_other_rd2", rf_if.ReadData2, 64'h1111_0000_0000_0008);
        drive(1'b1, 5'd7, 64'hA5A5_A5A5_A5A5_A5A5, 5'd7, 5'd7);
        check_val("t4_both_rd2", rf_if.ReadData2, 64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        drive(1'b0, 5'd0, 64'h0, 5'd7, 5'd8);
        check_val("t4_after_rd1", rf_if.ReadData1, 64'hA5A5_A5A5_A5A5_A5A5);
        check_val("t4_after_rd2", rf_if.ReadData2, 64'h1111_0000_0000_0008);

        // Test 5: disabled write neither bypasses nor stores
        drive(1'b0, 5'd3, 64'h1234, 5'd3, 5'd3);
        check_val("t5_no_bypass", rf_if.ReadData1, 64'h1111_0000_0000_0003);
        tick();
        drive(1'b0, 5'd0, 64'h0, 5'd3, 5'd0);
        check_val("t5_no_store", rf_if.ReadData1, 64'h1111_0000_0000_0003);

        // Test 6: reset wins over a same-cycle write and suppresses bypass
        reset = 1'b1;
        drive(1'b1, 5'd9, 64'h7777, 5'd9, 5'd10);
        check_val("t6_rd1_old", rf_if.ReadData1, 64'h1111_0000_0000_0009);
        check_val("t6_rd2_old", rf_if.ReadData2, 64'h1111_0000_0000_000A);
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 64'h0, 5'd9, 5'd10);
        check_val("t6_x9_zero", rf_if.ReadData1, 64'h0);
        check_val("t6_x10_zero", rf_if.ReadData2, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
